maze_store: RTL and testbench
=============================

# maze_store

Cell storage and I/O front end for the maze solver. Loads a 2^maze_width × 2^maze_width wall bitmap from a byte stream, then serves the solver's `maze_oe` reads and `maze_we` path marks. Once the solver raises `done`, it streams out the coordinates of every marked cell in row-major order. Sits directly on the solver's `row`/`col`/`maze_oe`/`maze_we`/`maze_in`/`done` pins.

## Interface

**Parameters**
- `maze_width`, default 6: coordinate width. Grid side is N = 2^maze_width. Must be ≥ 3.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: load byte valid.
- `load_data` in 8: 8 consecutive cells of one row. MSB is the lowest column. 1 = wall.
- `load_ready` out 1: block accepts a load byte.
- `maze_ready` out 1: maze loaded. Solver may run while this is high.
- `row`, `col` in maze_width: solver cell address.
- `maze_oe` in 1: read request.
- `maze_we` in 1: mark the cell at `row`/`col` as visited.
- `maze_in` out 1: registered wall bit returned to the solver.
- `done` in 1: solver finished.
- `path_valid` out 1: path coordinate valid.
- `path_row`, `path_col` out maze_width: coordinate of a visited cell.
- `path_ready` in 1: consumer accepts the coordinate.
- `dump_done` out 1: dump finished. Sticky until reset.

## Operation

**Storage**
- Two bits per cell: `wall` and `visited`.
- The array itself has no reset. It is fully rewritten by LOAD.

**FSM states:** LOAD → SOLVE → DUMP → FIN.

**LOAD**
- `load_ready` = 1.
- Handshake is `load_valid & load_ready` at a rising edge.
- Each accepted byte k (k = 0 … N²/8 − 1) targets row = k / (N/8), cols 8·(k mod N/8) … +7.
- A byte writes the `wall` bits of its 8 cells and clears their `visited` bits.
- 9-bit byte counter at w = 6. The acceptance of byte N²/8 − 1 moves the FSM to SOLVE.
- `maze_oe`, `maze_we` and `done` are ignored in this state.

**SOLVE**
- `maze_ready` = 1 and `load_ready` = 0. Load inputs are ignored.
- Read: `maze_oe` = 1 at edge t registers `maze_in` = `wall[row][col]`. The value holds until the next `maze_oe` edge.
- Write: `maze_we` = 1 at an edge sets `visited[row][col]`, whether or not the cell is a wall.
- `maze_oe` and `maze_we` together on the same cell: the read returns `wall` and the write still occurs.
- `done` = 1 at an edge moves the FSM to DUMP. A `maze_we` on that same edge is still performed.

**DUMP**
- `maze_ready` drops to 0. Solver inputs are ignored.
- A scan pointer runs from cell (0,0) to (N−1, N−1), column-fastest.
- The scanner advances one cell per cycle whenever the output register is empty or handshaking (`path_valid & path_ready`).
- For a visited cell it loads `path_row`/`path_col` and sets `path_valid`. Otherwise `path_valid` clears on that advance.
- `path_valid`, `path_row` and `path_col` stay stable while `path_valid` = 1 and `path_ready` = 0.
- After the last cell has been scanned and any pending coordinate accepted, the FSM moves to FIN.

**FIN**
- `dump_done` = 1. All inputs are ignored until reset.

## Timing

**Reset values:** state LOAD, `load_ready` 1, `maze_ready` 0, `maze_in` 0, `path_valid` 0, `path_row`/`path_col` 0, `dump_done` 0, all counters 0.

**Reset mid-operation:** asynchronous return to LOAD from any state. Stored cells keep their stale values until reloaded.

**Load**
- One byte per cycle maximum.
- `load_ready` is 0 in the cycle after the final byte's acceptance edge. `maze_ready` is 1 in that same cycle.

**Read latency:** one cycle. `maze_in` is valid after the edge that sampled `maze_oe`. This matches the solver's request-then-check state pairs.

**Dump**
- First `path_valid` appears no earlier than 1 cycle after entering DUMP.
- With `path_ready` held at 1, total dump length is N² + 1 cycles at most (4097 at w = 6).
- `dump_done` rises the cycle after FIN is entered.

## Test plan

1. **Reset:** pulse `rst_n` low mid-cycle → immediately `load_ready` = 1, `maze_ready` = 0, `path_valid` = 0, `dump_done` = 0, `maze_in` = 0.
2. **Load contents:** w = 6; load 512 bytes of 0x00, except byte 6 = 0x80 and byte 511 = 0x01. Drop `load_valid` for 3 cycles mid-stream → exactly 512 bytes are counted, and `maze_ready` = 1 the cycle after byte 511.
   - `maze_oe` at (0,48) → `maze_in` = 1 next cycle.
   - (0,49) → 0.
   - (63,63) → 1.
3. **Hold behaviour:** after a read returning 1, keep `maze_oe` = 0 and change `row`/`col` for 5 cycles → `maze_in` stays 1. Load inputs in SOLVE → no state change.
4. **Marks, done and dump:** `maze_we` at (3,4), (10,0), (3,5), then `done` = 1 on the same edge as `maze_we` at (63,0). Expected outputs in order: (3,4), (3,5), (10,0), (63,0).
   - Holding `path_ready` = 0 for 4 cycles on (3,5) keeps it stable.
   - `dump_done` = 1 afterwards; no further `path_valid`.
5. **Reload clears marks:** after FIN, reset and reload all zeros, mark nothing, assert `done` → no `path_valid` at all, and `dump_done` = 1 within 4097 cycles.
6. **Reset mid-dump:** assert `rst_n` = 0 while `path_valid` = 1 → `path_valid` = 0 and `load_ready` = 1 immediately. A subsequent full reload and solve behaves as in scenario 2.

Source files
------------

// File: rtl/maze_store_if.sv
// maze_store_if: load stream, solver cell port and path dump stream of the
// maze cell store. The store takes the slave side; the solver, loader and
// path consumer take the master side.
interface maze_store_if #(
    parameter int maze_width = 6
);
    // Load byte stream
    logic                  load_valid;
    logic [7:0]            load_data;
    logic                  load_ready;
    logic                  maze_ready;
    // Solver cell port
    logic [maze_width-1:0] row;
    logic [maze_width-1:0] col;
    logic                  maze_oe;
    logic                  maze_we;
    logic                  maze_in;
    logic                  done;
    // Path coordinate stream
    logic                  path_valid;
    logic [maze_width-1:0] path_row;
    logic [maze_width-1:0] path_col;
    logic                  path_ready;
    logic                  dump_done;

    modport slave (
        input  load_valid, load_data, row, col, maze_oe, maze_we, done, path_ready,
        output load_ready, maze_ready, maze_in, path_valid, path_row, path_col, dump_done
    );

    modport master (
        output load_valid, load_data, row, col, maze_oe, maze_we, done, path_ready,
        input  load_ready, maze_ready, maze_in, path_valid, path_row, path_col, dump_done
    );
endinterface

// File: rtl/maze_store.sv
// maze_store: wall/visited cell storage for the maze solver. Loads the wall
// bitmap from a byte stream, serves solver reads and path marks, then streams
// out the coordinates of every visited cell in row-major order.
module maze_store #(
    parameter int maze_width = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    maze_store_if.slave  bus
);
    localparam int N     = 1 << maze_width;
    localparam int CW    = 2 * maze_width;   // linear cell index width
    localparam int CNT_W = CW - 3;           // byte counter width

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SOLVE,
        ST_DUMP,
        ST_FIN
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      load_cnt;
    logic [CW-1:0]         scan_ptr;
    logic                  scan_end;

    logic                  load_ready_q;
    logic                  maze_ready_q;
    logic                  maze_in_q;
    logic                  path_valid_q;
    logic [maze_width-1:0] path_row_q;
    logic [maze_width-1:0] path_col_q;
    logic                  dump_done_q;

    // Cell arrays: one packed row per entry, bit index is the column.
    logic [N-1:0]          wall_mem    [N];
    logic [N-1:0]          visited_mem [N];

    logic                  load_fire;
    logic [CW-1:0]         ld_cell;
    logic [maze_width-1:0] ld_row;
    logic [maze_width-1:0] ld_col_base;
    logic [maze_width-1:0] ld_col [8];
    logic [maze_width-1:0] scan_row;
    logic [maze_width-1:0] scan_col;
    logic                  scan_vis;
    logic                  out_free;

    assign load_fire   = (state == ST_LOAD) && bus.load_valid && load_ready_q;
    assign ld_cell     = {load_cnt, 3'b000};
    assign ld_row      = ld_cell[CW-1:maze_width];
    assign ld_col_base = ld_cell[maze_width-1:0];
    assign scan_row    = scan_ptr[CW-1:maze_width];
    assign scan_col    = scan_ptr[maze_width-1:0];
    assign scan_vis    = visited_mem[scan_row][scan_col];
    assign out_free    = !path_valid_q || bus.path_ready;

    // Column of each of the 8 cells addressed by the current load byte.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            ld_col[i] = ld_col_base | maze_width'(i);
        end
    end

    // Cell array writes: load rewrites walls and clears marks, solver sets marks.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int unsigned i = 0; i < 8; i++) begin
                wall_mem[ld_row][ld_col[i]]    <= bus.load_data[3'(7 - i)];
                visited_mem[ld_row][ld_col[i]] <= 1'b0;
            end
        end
        if ((state == ST_SOLVE) && bus.maze_we) begin
            visited_mem[bus.row][bus.col] <= 1'b1;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            load_cnt     <= '0;
            scan_ptr     <= '0;
            scan_end     <= 1'b0;
            load_ready_q <= 1'b1;
            maze_ready_q <= 1'b0;
            maze_in_q    <= 1'b0;
            path_valid_q <= 1'b0;
            path_row_q   <= '0;
            path_col_q   <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        load_cnt <= load_cnt + CNT_W'(1);
                        if (load_cnt == '1) begin
                            state        <= ST_SOLVE;
                            load_ready_q <= 1'b0;
                            maze_ready_q <= 1'b1;
                        end
                    end
                end
                ST_SOLVE: begin
                    if (bus.maze_oe) begin
                        maze_in_q <= wall_mem[bus.row][bus.col];
                    end
                    if (bus.done) begin
                        state        <= ST_DUMP;
                        maze_ready_q <= 1'b0;
                        scan_ptr     <= '0;
                        scan_end     <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (out_free) begin
                        if (scan_end) begin
                            path_valid_q <= 1'b0;
                            state        <= ST_FIN;
                        end else begin
                            path_valid_q <= scan_vis;
                            if (scan_vis) begin
                                path_row_q <= scan_row;
                                path_col_q <= scan_col;
                            end
                            scan_ptr <= scan_ptr + CW'(1);
                            // An unmarked last cell leaves nothing pending, so finish at once.
                            if (scan_ptr == '1) begin
                                if (scan_vis) begin
                                    scan_end <= 1'b1;
                                end else begin
                                    state <= ST_FIN;
                                end
                            end
                        end
                    end
                end
                ST_FIN: begin
                    dump_done_q <= 1'b1;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.maze_ready = maze_ready_q;
    assign bus.maze_in    = maze_in_q;
    assign bus.path_valid = path_valid_q;
    assign bus.path_row   = path_row_q;
    assign bus.path_col   = path_col_q;
    assign bus.dump_done  = dump_done_q;

endmodule

// File: tb/tb_maze_store.sv
// tb_maze_store: directed bench for maze_store at maze_width = 6.
module tb_maze_store;
    localparam int W = 6;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    maze_store_if #(.maze_width(W)) bus ();

    maze_store #(.maze_width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_val(input int k, input int mode);
        if (mode == 0 && k == 6)   return 8'h80;
        if (mode == 0 && k == 511) return 8'h01;
        return 8'h00;
    endfunction

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_load_ready", 32'(bus.load_ready), 1);
        check("rst_maze_ready", 32'(bus.maze_ready), 0);
        check("rst_path_valid", 32'(bus.path_valid), 0);
        check("rst_dump_done",  32'(bus.dump_done), 0);
        check("rst_maze_in",    32'(bus.maze_in), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Stream 512 bytes with a 3-cycle valid gap in the middle.
    task automatic load_maze(input int mode);
        for (int k = 0; k < 512; k++) begin
            if (k == 100) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'hFF;
                repeat (3) tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = byte_val(k, mode);
            tick();
            if (k == 510) begin
                check("maze_ready_before_last", 32'(bus.maze_ready), 0);
                check("load_ready_before_last", 32'(bus.load_ready), 1);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        check("maze_ready_after_last", 32'(bus.maze_ready), 1);
        check("load_ready_after_last", 32'(bus.load_ready), 0);
    endtask

    task automatic read_cell(input string tag, input int r, input int c, input logic exp);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_oe = 1'b1;
        tick();
        bus.maze_oe = 1'b0;
        check(tag, 32'(bus.maze_in), 32'(exp));
    endtask

    task automatic mark_cell(input int r, input int c, input logic fin);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_we = 1'b1;
        bus.done    = fin;
        tick();
        bus.maze_we = 1'b0;
        bus.done    = 1'b0;
    endtask

    initial begin
        logic [11:0] got_q[$];
        logic [11:0] exp_q[4];
        int          cycles;
        bit          held;
        bit          seen;

        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.row        = '0;
        bus.col        = '0;
        bus.maze_oe    = 1'b0;
        bus.maze_we    = 1'b0;
        bus.done       = 1'b0;
        bus.path_ready = 1'b1;
        exp_q[0] = {6'd3, 6'd4};
        exp_q[1] = {6'd3, 6'd5};
        exp_q[2] = {6'd10, 6'd0};
        exp_q[3] = {6'd63, 6'd0};

        // Reset and load the test pattern
        tick();
        do_reset();
        load_maze(0);

        // Reads: wall bits and their neighbours
        read_cell("rd_0_47", 0, 47, 1'b0);
        read_cell("rd_0_48", 0, 48, 1'b1);
        read_cell("rd_0_49", 0, 49, 1'b0);
        read_cell("rd_63_62", 63, 62, 1'b0);
        read_cell("rd_63_63", 63, 63, 1'b1);

        // maze_in holds without maze_oe
        for (int i = 0; i < 5; i++) begin
            bus.row = 6'(i);
            bus.col = 6'(i + 48);
            tick();
            check("hold_maze_in", 32'(bus.maze_in), 1);
        end

        // Load inputs ignored in SOLVE
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        repeat (2) tick();
        bus.load_valid = 1'b0;
        check("solve_load_ready", 32'(bus.load_ready), 0);
        check("solve_maze_ready", 32'(bus.maze_ready), 1);
        read_cell("rd_0_0_after_junk", 0, 0, 1'b0);

        // Marks, with the last one on the done edge
        mark_cell(3, 4, 1'b0);
        mark_cell(10, 0, 1'b0);
        mark_cell(3, 5, 1'b0);
        mark_cell(63, 0, 1'b1);
        check("dump_maze_ready", 32'(bus.maze_ready), 0);

        // Collect the dump, stalling on (3,5)
        cycles = 0;
        held   = 1'b0;
        bus.path_ready = 1'b1;
        while (!bus.dump_done && cycles < 5000) begin
            if (bus.path_valid) begin
                if (bus.path_row == 6'd3 && bus.path_col == 6'd5 && !held) begin
                    held = 1'b1;
                    bus.path_ready = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        check("stall_valid", 32'(bus.path_valid), 1);
                        check("stall_row", 32'(bus.path_row), 3);
                        check("stall_col", 32'(bus.path_col), 5);
                    end
                    bus.path_ready = 1'b1;
                end
                got_q.push_back({bus.path_row, bus.path_col});
            end
            tick();
            cycles++;
        end
        check("dump_timeout", 32'(cycles < 5000), 1);
        check("dump_count", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check("dump_coord", 32'(got_q[i]), 32'(exp_q[i]));
        end
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (bus.path_valid) seen = 1'b1;
        end
        check("fin_no_valid", 32'(seen), 0);
        check("fin_dump_done", 32'(bus.dump_done), 1);

        // Reload all zeros: old marks must be gone
        do_reset();
        load_maze(1);
        read_cell("zero_rd_0_48", 0, 48, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!bus.dump_done && cycles < 5000) begin
            if (bus.path_valid) seen = 1'b1;
            tick();
            cycles++;
        end
        check("empty_no_valid", 32'(seen), 0);
        check("empty_dump_len", 32'(cycles <= 4097), 1);

        // Reset while a coordinate is pending
        do_reset();
        load_maze(0);
        mark_cell(3, 4, 1'b1);
        bus.path_ready = 1'b0;
        cycles = 0;
        while (!bus.path_valid && cycles < 5000) begin
            tick();
            cycles++;
        end
        check("middump_valid", 32'(bus.path_valid), 1);
        check("middump_coord", 32'({bus.path_row, bus.path_col}), 32'({6'd3, 6'd4}));
        bus.path_ready = 1'b1;
        do_reset();
        load_maze(0);
        read_cell("re_rd_0_48", 0, 48, 1'b1);
        read_cell("re_rd_0_49", 0, 49, 1'b0);
        read_cell("re_rd_63_63", 63, 63, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
